// File: rtl/multicycle_cu.sv
// multicycle_cu: control unit for the shared multi-cycle MIPS datapath
// (single memory, single ALU, IR/A/B/ALUOut/MDR registers).
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   opCode            IR[31:26], valid from DECODE onward
//   Zero              ALU zero flag from the branch comparison
//   Mem_Ready         memory finishes the access this cycle
//   PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, IR_Write,
//   Mem_To_Reg, Reg_Dst, Reg_Write, ALU_Src_A, ALU_Src_B, ALU_Op, PC_Src
//                     datapath mux selects and enables, decoded from state
//   Mem_Err           one-cycle pulse when a memory wait times out
//   Illegal_Op        one-cycle pulse in DECODE for an unsupported opcode
//   Retired           count of completed instructions (wraps)
module multicycle_cu #(
  parameter int unsigned WAIT_MAX = 8,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opCode,
  input  logic             Zero,
  input  logic             Mem_Ready,
  output logic             PC_Write,
  output logic             PC_Write_Cond,
  output logic             IorD,
  output logic             Mem_Read,
  output logic             Mem_Write,
  output logic             IR_Write,
  output logic             Mem_To_Reg,
  output logic             Reg_Dst,
  output logic             Reg_Write,
  output logic             ALU_Src_A,
  output logic [1:0]       ALU_Src_B,
  output logic [1:0]       ALU_Op,
  output logic [1:0]       PC_Src,
  output logic             Mem_Err,
  output logic             Illegal_Op,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [7:0] WAIT_LIM = 8'(WAIT_MAX);

  state_t           state;
  state_t           next;
  logic [7:0]       wait_cnt;
  logic [CNT_W-1:0] retired;
  logic             mem_state;
  logic             timeout;
  logic             retire;
  logic             illegal;

  assign mem_state = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
  // Mem_Ready arriving on the limit cycle is a normal completion.
  assign timeout   = mem_state && (wait_cnt == WAIT_LIM) && !Mem_Ready;
  assign Retired   = retired;

  always_comb begin
    next    = state;
    retire  = 1'b0;
    illegal = 1'b0;
    case (state)
      FETCH: begin
        if (Mem_Ready)    next = DECODE;
        else if (timeout) next = FETCH;
      end
      DECODE: begin
        case (opCode)
          OP_R:           next = EXEC_R;
          OP_LW, OP_SW:   next = MEM_ADDR;
          OP_ADDI:        next = EXEC_I;
          OP_BEQ, OP_BNE: next = BRANCH;
          OP_J:           next = JUMP;
          default: begin
            next    = FETCH;
            illegal = 1'b1;
          end
        endcase
      end
      MEM_ADDR: next = (opCode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (Mem_Ready)    next = MEM_WB;
        else if (timeout) next = FETCH;
      end
      MEM_WB: begin
        next   = FETCH;
        retire = 1'b1;
      end
      MEM_WR: begin
        if (Mem_Ready) begin
          next   = FETCH;
          retire = 1'b1;
        end else if (timeout) begin
          next = FETCH;
        end
      end
      EXEC_R: next = WB_R;
      WB_R: begin
        next   = FETCH;
        retire = 1'b1;
      end
      EXEC_I: next = WB_I;
      WB_I: begin
        next   = FETCH;
        retire = 1'b1;
      end
      BRANCH, JUMP: begin
        next   = FETCH;
        retire = 1'b1;
      end
      default: next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= next;
      // Counting only while stalled in a memory state clears it on every
      // entry, including the FETCH -> FETCH re-entry after a timeout.
      if (mem_state && !Mem_Ready && !timeout) wait_cnt <= wait_cnt + 8'd1;
      else                                      wait_cnt <= '0;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    PC_Write      = 1'b0;
    PC_Write_Cond = 1'b0;
    IorD          = 1'b0;
    Mem_Read      = 1'b0;
    Mem_Write     = 1'b0;
    IR_Write      = 1'b0;
    Mem_To_Reg    = 1'b0;
    Reg_Dst       = 1'b0;
    Reg_Write     = 1'b0;
    ALU_Src_A     = 1'b0;
    ALU_Src_B     = 2'b00;
    ALU_Op        = 2'b00;
    PC_Src        = 2'b00;
    Mem_Err       = 1'b0;
    Illegal_Op    = 1'b0;
    if (!rst) begin
      Mem_Err    = timeout;
      Illegal_Op = illegal;
      case (state)
        FETCH: begin
          Mem_Read  = 1'b1;
          ALU_Src_B = 2'b01;
          IR_Write  = Mem_Ready;
          PC_Write  = Mem_Ready;
        end
        DECODE: ALU_Src_B = 2'b11;
        MEM_ADDR, EXEC_I: begin
          ALU_Src_A = 1'b1;
          ALU_Src_B = 2'b10;
        end
        MEM_RD: begin
          Mem_Read = 1'b1;
          IorD     = 1'b1;
        end
        MEM_WB: begin
          Reg_Write  = 1'b1;
          Mem_To_Reg = 1'b1;
        end
        MEM_WR: begin
          Mem_Write = !timeout;
          IorD      = 1'b1;
        end
        EXEC_R: begin
          ALU_Src_A = 1'b1;
          ALU_Op    = 2'b10;
        end
        WB_R: begin
          Reg_Write = 1'b1;
          Reg_Dst   = 1'b1;
        end
        WB_I: Reg_Write = 1'b1;
        BRANCH: begin
          ALU_Src_A     = 1'b1;
          ALU_Op        = 2'b01;
          PC_Src        = 2'b01;
          PC_Write_Cond = (opCode == OP_BNE) ? !Zero : Zero;
        end
        JUMP: begin
          PC_Write = 1'b1;
          PC_Src   = 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_cu.sv
// Testbench for multicycle_cu: a per-cycle vector table of inputs and
// expected control word / Retired count, checked through a scoreboard queue.
module tb_multicycle_cu;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opCode;
  logic        Zero;
  logic        Mem_Ready;
  logic        PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, IR_Write;
  logic        Mem_To_Reg, Reg_Dst, Reg_Write, ALU_Src_A;
  logic [1:0]  ALU_Src_B, ALU_Op, PC_Src;
  logic        Mem_Err, Illegal_Op;
  logic [31:0] Retired;

  multicycle_cu #(.WAIT_MAX(8), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .Zero(Zero), .Mem_Ready(Mem_Ready),
    .PC_Write(PC_Write), .PC_Write_Cond(PC_Write_Cond), .IorD(IorD),
    .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .IR_Write(IR_Write),
    .Mem_To_Reg(Mem_To_Reg), .Reg_Dst(Reg_Dst), .Reg_Write(Reg_Write),
    .ALU_Src_A(ALU_Src_A), .ALU_Src_B(ALU_Src_B), .ALU_Op(ALU_Op),
    .PC_Src(PC_Src), .Mem_Err(Mem_Err), .Illegal_Op(Illegal_Op),
    .Retired(Retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic        zero;
    logic        rdy;
    logic [17:0] ctl;
    logic [31:0] ret;
  } vec_t;

  typedef struct {
    logic [17:0] ctl;
    logic [31:0] ret;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // {PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, IR_Write, Mem_To_Reg,
  //  Reg_Dst, Reg_Write, ALU_Src_A, ALU_Src_B, ALU_Op, PC_Src, Mem_Err, Illegal_Op}
  function automatic logic [17:0] c(
    input logic pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, sa,
    input logic [1:0] sb_, op, ps, input logic me, il);
    return {pcw, pcc, iord, mr, mw, irw, m2r, rd, rw, sa, sb_, op, ps, me, il};
  endfunction

  logic [17:0] K_ZERO, K_F_RDY, K_F_WAIT, K_F_TO, K_DEC, K_DEC_ILL, K_MADDR;
  logic [17:0] K_MRD, K_MWB, K_MWR, K_MWR_TO, K_EXR, K_WBR, K_WBI;
  logic [17:0] K_BR_T, K_BR_N, K_JMP;

  task automatic add(input logic r, input logic [5:0] op, input logic z,
                     input logic rdy, input logic [17:0] ctl, input int ret);
    vec_t v;
    v.rst = r; v.op = op; v.zero = z; v.rdy = rdy; v.ctl = ctl; v.ret = ret;
    vecs.push_back(v);
  endtask

  function automatic logic [17:0] dut_ctl();
    return {PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, IR_Write,
            Mem_To_Reg, Reg_Dst, Reg_Write, ALU_Src_A, ALU_Src_B, ALU_Op,
            PC_Src, Mem_Err, Illegal_Op};
  endfunction

  initial begin
    exp_t e;
    K_ZERO    = '0;
    K_F_RDY   = c(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    K_F_WAIT  = c(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
    K_F_TO    = c(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,1,0);
    K_DEC     = c(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
    K_DEC_ILL = c(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,1);
    K_MADDR   = c(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
    K_MRD     = c(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    K_MWB     = c(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0);
    K_MWR     = c(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
    K_MWR_TO  = c(0,0,1,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1,0);
    K_EXR     = c(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
    K_WBR     = c(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0);
    K_WBI     = c(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0);
    K_BR_T    = c(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0);
    K_BR_N    = c(0,0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0);
    K_JMP     = c(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0,0);

    // reset cycle: outputs forced low
    add(1, 6'o00, 0, 1, K_ZERO, 0);
    // R-type: 4 cycles, retire
    add(0, 6'b000000, 0, 1, K_F_RDY, 0);
    add(0, 6'b000000, 0, 1, K_DEC,   0);
    add(0, 6'b000000, 0, 1, K_EXR,   0);
    add(0, 6'b000000, 0, 1, K_WBR,   0);
    // lw with three stall cycles in MEM_RD: 8 cycles
    add(0, 6'b100011, 0, 1, K_F_RDY, 1);
    add(0, 6'b100011, 0, 1, K_DEC,   1);
    add(0, 6'b100011, 0, 1, K_MADDR, 1);
    add(0, 6'b100011, 0, 0, K_MRD,   1);
    add(0, 6'b100011, 0, 0, K_MRD,   1);
    add(0, 6'b100011, 0, 0, K_MRD,   1);
    add(0, 6'b100011, 0, 1, K_MRD,   1);
    add(0, 6'b100011, 0, 1, K_MWB,   1);
    // beq, Zero=1: taken
    add(0, 6'b000100, 1, 1, K_F_RDY, 2);
    add(0, 6'b000100, 1, 1, K_DEC,   2);
    add(0, 6'b000100, 1, 1, K_BR_T,  2);
    // bne, Zero=1: not taken, still retires
    add(0, 6'b000101, 1, 1, K_F_RDY, 3);
    add(0, 6'b000101, 1, 1, K_DEC,   3);
    add(0, 6'b000101, 1, 1, K_BR_N,  3);
    // addi
    add(0, 6'b001000, 0, 1, K_F_RDY, 4);
    add(0, 6'b001000, 0, 1, K_DEC,   4);
    add(0, 6'b001000, 0, 1, K_MADDR, 4);
    add(0, 6'b001000, 0, 1, K_WBI,   4);
    // sw without stalls: 4 cycles
    add(0, 6'b101011, 0, 1, K_F_RDY, 5);
    add(0, 6'b101011, 0, 1, K_DEC,   5);
    add(0, 6'b101011, 0, 1, K_MADDR, 5);
    add(0, 6'b101011, 0, 1, K_MWR,   5);
    // FETCH timeout: counts 0..7 wait, count 8 errors, re-enter FETCH
    for (int i = 0; i < 8; i++) add(0, 6'b111111, 0, 0, K_F_WAIT, 6);
    add(0, 6'b111111, 0, 0, K_F_TO,   6);
    add(0, 6'b111111, 0, 0, K_F_WAIT, 6);
    add(0, 6'b111111, 0, 1, K_F_RDY,  6);
    // illegal opcode, then jump
    add(0, 6'b111111, 0, 1, K_DEC_ILL, 6);
    add(0, 6'b000010, 0, 1, K_F_RDY,   6);
    add(0, 6'b000010, 0, 1, K_DEC,     6);
    add(0, 6'b000010, 0, 1, K_JMP,     6);
    // sw: Mem_Ready arrives on the limit cycle -> normal completion
    add(0, 6'b101011, 0, 1, K_F_RDY, 7);
    add(0, 6'b101011, 0, 1, K_DEC,   7);
    add(0, 6'b101011, 0, 1, K_MADDR, 7);
    for (int i = 0; i < 8; i++) add(0, 6'b101011, 0, 0, K_MWR, 7);
    add(0, 6'b101011, 0, 1, K_MWR, 7);
    // sw timeout: write suppressed, no retire
    add(0, 6'b101011, 0, 1, K_F_RDY, 8);
    add(0, 6'b101011, 0, 1, K_DEC,   8);
    add(0, 6'b101011, 0, 1, K_MADDR, 8);
    for (int i = 0; i < 8; i++) add(0, 6'b101011, 0, 0, K_MWR, 8);
    add(0, 6'b101011, 0, 0, K_MWR_TO, 8);
    add(0, 6'b101011, 0, 1, K_F_RDY,  8);
    // reset during MEM_WR aborts the store and clears Retired
    add(0, 6'b101011, 0, 1, K_DEC,   8);
    add(0, 6'b101011, 0, 1, K_MADDR, 8);
    add(0, 6'b101011, 0, 0, K_MWR,   8);
    add(1, 6'b101011, 0, 1, K_ZERO,  8);
    add(0, 6'b101011, 0, 0, K_F_WAIT, 0);

    // initial reset edge so Retired is defined before the first vector
    rst = 1'b1; opCode = '0; Zero = 1'b0; Mem_Ready = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      rst = vecs[i].rst; opCode = vecs[i].op; Zero = vecs[i].zero;
      Mem_Ready = vecs[i].rdy;
      e.ctl = vecs[i].ctl; e.ret = vecs[i].ret;
      sb.push_back(e);
      @(negedge clk);
      e = sb.pop_front();
      n_vec++;
      if (dut_ctl() !== e.ctl || Retired !== e.ret) begin
        n_bad++;
        $display("FAIL vec%0d: ctl=%b retired=%0d, required ctl=%b retired=%0d",
                 i, dut_ctl(), Retired, e.ctl, e.ret);
      end
      if (Mem_Read === 1'b1 && Mem_Write === 1'b1) begin
        n_bad++;
        $display("FAIL rdwr_excl vec%0d: Mem_Read=1 Mem_Write=1, required not both", i);
      end
      @(posedge clk); #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
Multi-cycle control unit that sequences the shared MIPS datapath (single memory, single ALU, IR/A/B/ALUOut/MDR registers) through fetch, decode, execute, memory and writeback states.
- Replaces the single-cycle opcode decoder.
- Drives every datapath mux/enable per state.
- Stalls on a memory-ready handshake with a timeout.
- Counts retired instructions.

Parameters:
WAIT_MAX, 8, maximum cycles any memory state waits for Mem_Ready before aborting (1..255)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
opCode  input  6  IR[31:26], valid from DECODE onward
Zero  input  1  ALU zero flag from the EXEC-stage comparison
Mem_Ready  input  1  memory completes the access in the current cycle
PC_Write  output  1  unconditional PC load
PC_Write_Cond  output  1  PC load qualified by branch outcome (computed internally, see Behaviour)
IorD  output  1  memory address select: 0 PC, 1 ALUOut
Mem_Read  output  1  memory read request
Mem_Write  output  1  memory write request
IR_Write  output  1  load instruction register
Mem_To_Reg  output  1  writeback data: 1 MDR, 0 ALUOut
Reg_Dst  output  1  dest register: 1 rd, 0 rt
Reg_Write  output  1  register-file write enable
ALU_Src_A  output  1  0 PC, 1 A
ALU_Src_B  output  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
ALU_Op  output  2  00 add, 01 subtract, 10 funct-decoded
PC_Src  output  2  00 ALU result, 01 ALUOut, 10 jump target
Mem_Err  output  1  one-cycle pulse on memory timeout
Illegal_Op  output  1  one-cycle pulse on unsupported opcode
Retired  output  CNT_W  count of completed instructions

Behaviour:
- One clock: clk. Reset is synchronous and active-high on rst.
- Reset, sampled on a rising edge:
  - State goes to FETCH.
  - Wait counter and Retired clear to 0.
  - Mem_Err and Illegal_Op clear to 0.
  - While rst is high, all control outputs are forced to 0.
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC_R, WB_R, EXEC_I, WB_I, BRANCH, JUMP.
- Control outputs are combinational from state (plus Mem_Ready/Zero where noted). Unlisted outputs are 0.
- FETCH:
  - Mem_Read=1, IorD=0, ALU_Src_A=0, ALU_Src_B=01, ALU_Op=00, PC_Src=00.
  - IR_Write=PC_Write=Mem_Ready.
  - Mem_Ready=1 -> DECODE. Otherwise stay.
- DECODE: ALU_Src_A=0, ALU_Src_B=11, ALU_Op=00 (branch target into ALUOut). Next state by opCode:
  - 000000 -> EXEC_R
  - 100011, 101011 -> MEM_ADDR
  - 001000 (addi) -> EXEC_I
  - 000100, 000101 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> FETCH, with Illegal_Op pulsed for one cycle. The instruction is not counted.
- MEM_ADDR: ALU_Src_A=1, ALU_Src_B=10, ALU_Op=00. Next is MEM_RD for lw, MEM_WR for sw. opCode is held stable by IR.
- MEM_RD: Mem_Read=1, IorD=1. Mem_Ready -> MEM_WB.
- MEM_WB: Reg_Write=1, Mem_To_Reg=1, Reg_Dst=0 -> FETCH; retire.
- MEM_WR: Mem_Write=1, IorD=1. Mem_Ready -> FETCH; retire.
- EXEC_R: ALU_Src_A=1, ALU_Src_B=00, ALU_Op=10 -> WB_R.
- WB_R: Reg_Write=1, Reg_Dst=1, Mem_To_Reg=0 -> FETCH; retire.
- EXEC_I: ALU_Src_A=1, ALU_Src_B=10, ALU_Op=00 -> WB_I.
- WB_I: Reg_Write=1, Reg_Dst=0, Mem_To_Reg=0 -> FETCH; retire.
- BRANCH:
  - ALU_Src_A=1, ALU_Src_B=00, ALU_Op=01, PC_Src=01.
  - PC_Write_Cond = Zero for beq, ~Zero for bne.
  - -> FETCH; retire regardless of taken/not-taken.
- JUMP: PC_Write=1, PC_Src=10 -> FETCH; retire.
- Retire: Retired increments by 1 on the exit edge of the final state. Wraps modulo 2^CNT_W.
- Memory wait counter (FETCH, MEM_RD, MEM_WR):
  - Cleared on entry to each of these states; increments each cycle Mem_Ready=0.
  - If it reaches WAIT_MAX with Mem_Ready still 0: pulse Mem_Err, go to FETCH, suppress all writes in that cycle, do not retire.
  - Mem_Ready in the same cycle as the WAIT_MAX count wins: a normal completion, no error.
- Mem_Read and Mem_Write are never both 1.
- Latency without stalls (cycles, including FETCH):
  - R-type 4, addi 4, lw 5, sw 4, beq/bne 3, j 3.
- rst asserted mid-instruction aborts it: no partial writes after the reset edge, no retire.

Test Plan:
- Reset, then R-type (opCode 000000), Mem_Ready=1 always -> states FETCH, DECODE, EXEC_R, WB_R; Reg_Write=1/Reg_Dst=1 only in WB_R; Retired=1 after 4 cycles.
- lw (100011) with Mem_Ready=0 for 3 cycles in MEM_RD -> stays in MEM_RD 4 cycles, then MEM_WB with Mem_To_Reg=1; total 8 cycles; Retired increments by 1.
- beq with Zero=1 -> PC_Write_Cond=1 in BRANCH. bne with Zero=1 -> PC_Write_Cond=0. Each takes 3 cycles and retires.
- FETCH with Mem_Ready held 0, WAIT_MAX=8 -> Mem_Err pulses once at count 8, IR_Write never 1, state returns to FETCH, Retired unchanged.
- opCode 111111 -> Illegal_Op pulses in DECODE, next state FETCH, Retired unchanged. Then j (000010) -> PC_Write=1, PC_Src=10 in JUMP.
- rst raised during MEM_WR -> next state FETCH, Mem_Write=0 while rst is high, Retired=0.
